// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a loaded value down to zero and emits a one-cycle done pulse.
// Optional periodic mode: define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN to reload from the last loaded value.
//
// state  | meaning
// S_IDLE | stopped, count held, enable ignored
// S_RUN  | counting down on enabled cycles, busy=1
// S_DONE | single cycle after the terminal edge, done=1, count=0
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] reload_q, reload_n;
    logic [WIDTH-1:0] count_n;
    logic             busy_n;
    logic             done_n;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count    <= '0;
            reload_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_n;
            count    <= count_n;
            reload_q <= reload_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        count_n  = count;
        reload_n = reload_q;
        busy_n   = busy;
        done_n   = 1'b0;

        if (load) begin
            count_n  = load_value;
            reload_n = load_value;
            if (load_value != '0) begin
                state_n = S_RUN;
                busy_n  = 1'b1;
            end else begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_n = 1'b0;
                end
                S_RUN: begin
                    busy_n = 1'b1;
                    // count==0 never occurs in RUN; treating it as terminal keeps 0 from wrapping
                    if (enable) begin
                        if (count <= WIDTH'(1)) begin
                            done_n = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                            count_n = reload_q;
                            state_n = S_RUN;
                            busy_n  = 1'b1;
`else
                            count_n = '0;
                            state_n = S_DONE;
                            busy_n  = 1'b0;
`endif
                        end else begin
                            count_n = count - WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
                default: begin
                    state_n = S_IDLE;
                    count_n = '0;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

endmodule
